// File: rtl/fwd_hazard_unit.sv
// Forwarding/interlock unit at the ID/EX boundary: shadows in-flight writers,
// produces registered EX operand selects and a combinational load-use stall.
module fwd_hazard_unit #(
  parameter int unsigned RA_W  = 5,
  parameter int unsigned DEPTH = 3,
  parameter int unsigned LAT_W = 2,
  parameter int unsigned SEL_W = $clog2(DEPTH + 1),
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [RA_W-1:0]  id_rs,
  input  logic [RA_W-1:0]  id_rt,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic [RA_W-1:0]  id_rw,
  input  logic             id_regWr,
  input  logic [LAT_W-1:0] id_lat,
  input  logic             id_flush,
  output logic             stall,
  output logic [SEL_W-1:0] ex_fwdA,
  output logic [SEL_W-1:0] ex_fwdB,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic             v;
    logic [RA_W-1:0]  rw;
    logic [LAT_W-1:0] lat;
  } sb_entry_t;

  sb_entry_t        sb_q [DEPTH];
  sb_entry_t        entry0_c;

  logic             found_a_c;
  logic             found_b_c;
  logic             haz_a_c;
  logic             haz_b_c;
  logic [SEL_W-1:0] sel_a_c;
  logic [SEL_W-1:0] sel_b_c;
  logic             transfer_c;

  // Youngest-match lookup per operand; a match younger than its latency is a hazard.
  always_comb begin
    found_a_c = 1'b0;
    found_b_c = 1'b0;
    haz_a_c   = 1'b0;
    haz_b_c   = 1'b0;
    sel_a_c   = '0;
    sel_b_c   = '0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      if (!found_a_c && id_valid && id_rs_used && (id_rs != '0) &&
          sb_q[k].v && (sb_q[k].rw == id_rs)) begin
        found_a_c = 1'b1;
        if ((k + 1) >= int'(sb_q[k].lat)) begin
          sel_a_c = SEL_W'(k + 1);
        end else begin
          haz_a_c = 1'b1;
        end
      end
      if (!found_b_c && id_valid && id_rt_used && (id_rt != '0) &&
          sb_q[k].v && (sb_q[k].rw == id_rt)) begin
        found_b_c = 1'b1;
        if ((k + 1) >= int'(sb_q[k].lat)) begin
          sel_b_c = SEL_W'(k + 1);
        end else begin
          haz_b_c = 1'b1;
        end
      end
    end
  end

  assign stall      = id_valid & ~id_flush & (haz_a_c | haz_b_c);
  assign transfer_c = id_valid & ~id_flush & ~stall;

  // New EX-stage entry: a bubble unless the ID instruction actually moves.
  always_comb begin
    entry0_c = '0;
    if (transfer_c) begin
      entry0_c.v   = id_regWr & (id_rw != '0);
      entry0_c.rw  = id_rw;
      entry0_c.lat = (id_lat == '0) ? LAT_W'(1) : id_lat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < int'(DEPTH); k++) begin
        sb_q[k] <= '0;
      end
      ex_fwdA   <= '0;
      ex_fwdB   <= '0;
      stall_cnt <= '0;
    end else begin
      for (int k = int'(DEPTH) - 1; k > 0; k--) begin
        sb_q[k] <= sb_q[k-1];
      end
      sb_q[0]   <= entry0_c;
      ex_fwdA   <= transfer_c ? sel_a_c : '0;
      ex_fwdB   <= transfer_c ? sel_b_c : '0;
      if (stall && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: hand-computed stalls, selects and counts.
module tb_fwd_hazard_unit;

  localparam int unsigned RA_W  = 5;
  localparam int unsigned DEPTH = 3;
  localparam int unsigned LAT_W = 2;
  localparam int unsigned SEL_W = 2;
  localparam int unsigned CNT_W = 8;

  logic             clk;
  logic             rst;
  logic             id_valid;
  logic [RA_W-1:0]  id_rs;
  logic [RA_W-1:0]  id_rt;
  logic             id_rs_used;
  logic             id_rt_used;
  logic [RA_W-1:0]  id_rw;
  logic             id_regWr;
  logic [LAT_W-1:0] id_lat;
  logic             id_flush;
  logic             stall;
  logic [SEL_W-1:0] ex_fwdA;
  logic [SEL_W-1:0] ex_fwdB;
  logic [CNT_W-1:0] stall_cnt;

  int tests_run = 0;
  int tests_failed = 0;

  fwd_hazard_unit #(
    .RA_W(RA_W), .DEPTH(DEPTH), .LAT_W(LAT_W), .SEL_W(SEL_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rw(id_rw),
    .id_regWr(id_regWr), .id_lat(id_lat), .id_flush(id_flush), .stall(stall),
    .ex_fwdA(ex_fwdA), .ex_fwdB(ex_fwdB), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present one ID instruction for a cycle; leaves time for stall to settle.
  task automatic issue(input logic v, input logic [4:0] rs, input logic rsu,
                       input logic [4:0] rt, input logic rtu, input logic [4:0] rw,
                       input logic wr, input logic [1:0] lat, input logic fl);
    @(posedge clk);
    #1;
    id_valid = v;  id_rs = rs;  id_rs_used = rsu;  id_rt = rt;  id_rt_used = rtu;
    id_rw = rw;  id_regWr = wr;  id_lat = lat;  id_flush = fl;
    #1;
  endtask

  task automatic nop();
    issue(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic hold();
    @(posedge clk);
    #2;
  endtask

  task automatic randomize_id();
    id_valid = 1'($urandom);  id_rs = 5'($urandom);  id_rt = 5'($urandom);
    id_rs_used = 1'($urandom);  id_rt_used = 1'($urandom);  id_rw = 5'($urandom);
    id_regWr = 1'($urandom);  id_lat = 2'($urandom);  id_flush = 1'($urandom);
  endtask

  initial begin
    rst = 1'b1;
    randomize_id();
    repeat (2) begin
      @(posedge clk);
      #1;
      randomize_id();
    end
    rst = 1'b0;
    #1;
    check_eq("reset_stall", 32'(stall), 32'd0);
    check_eq("reset_fwdA", 32'(ex_fwdA), 32'd0);
    check_eq("reset_fwdB", 32'(ex_fwdB), 32'd0);
    check_eq("reset_cnt", 32'(stall_cnt), 32'd0);
    repeat (3) nop();

    // ALU producer feeding the next instruction
    issue(1, 5'd0, 0, 5'd0, 0, 5'd3, 1, 2'd1, 0);
    check_eq("alu_prod_stall", 32'(stall), 32'd0);
    issue(1, 5'd3, 1, 5'd0, 0, 5'd0, 0, 2'd1, 0);
    check_eq("alu_cons_stall", 32'(stall), 32'd0);
    nop();
    check_eq("alu_fwdA", 32'(ex_fwdA), 32'd1);
    check_eq("alu_fwdB", 32'(ex_fwdB), 32'd0);

    // Load-use on both operands: one stall cycle then MEM/WB forward
    issue(1, 5'd0, 0, 5'd0, 0, 5'd4, 1, 2'd2, 0);
    issue(1, 5'd4, 1, 5'd4, 1, 5'd0, 0, 2'd1, 0);
    check_eq("lu_stall1", 32'(stall), 32'd1);
    hold();
    check_eq("lu_stall2", 32'(stall), 32'd0);
    check_eq("lu_bubble_fwdA", 32'(ex_fwdA), 32'd0);
    check_eq("lu_bubble_fwdB", 32'(ex_fwdB), 32'd0);
    check_eq("lu_cnt", 32'(stall_cnt), 32'd1);
    nop();
    check_eq("lu_fwdA", 32'(ex_fwdA), 32'd2);
    check_eq("lu_fwdB", 32'(ex_fwdB), 32'd2);

    // Youngest of two writers wins
    issue(1, 5'd0, 0, 5'd0, 0, 5'd5, 1, 2'd1, 0);
    issue(1, 5'd0, 0, 5'd0, 0, 5'd5, 1, 2'd1, 0);
    issue(1, 5'd0, 0, 5'd5, 1, 5'd0, 0, 2'd1, 0);
    check_eq("yw_stall", 32'(stall), 32'd0);
    nop();
    check_eq("yw_fwdB", 32'(ex_fwdB), 32'd1);
    check_eq("yw_fwdA", 32'(ex_fwdA), 32'd0);

    // Unready youngest stalls although an older ready match exists
    issue(1, 5'd0, 0, 5'd0, 0, 5'd6, 1, 2'd1, 0);
    issue(1, 5'd0, 0, 5'd0, 0, 5'd6, 1, 2'd2, 0);
    issue(1, 5'd6, 1, 5'd0, 0, 5'd0, 0, 2'd1, 0);
    check_eq("uy_stall1", 32'(stall), 32'd1);
    hold();
    check_eq("uy_stall2", 32'(stall), 32'd0);
    nop();
    check_eq("uy_fwdA", 32'(ex_fwdA), 32'd2);

    // Oldest tracked entry forwards with sel = DEPTH
    issue(1, 5'd0, 0, 5'd0, 0, 5'd5, 1, 2'd1, 0);
    nop();
    nop();
    issue(1, 5'd5, 1, 5'd0, 0, 5'd0, 0, 2'd1, 0);
    check_eq("d3_stall", 32'(stall), 32'd0);
    nop();
    check_eq("d3_fwdA", 32'(ex_fwdA), 32'd3);

    // Writer four stages ahead comes from the register file
    issue(1, 5'd0, 0, 5'd0, 0, 5'd5, 1, 2'd1, 0);
    nop();
    nop();
    nop();
    issue(1, 5'd5, 1, 5'd0, 0, 5'd0, 0, 2'd1, 0);
    check_eq("d4_stall", 32'(stall), 32'd0);
    nop();
    check_eq("d4_fwdA", 32'(ex_fwdA), 32'd0);

    // Latency DEPTH back-to-back: DEPTH-1 stall cycles
    issue(1, 5'd0, 0, 5'd0, 0, 5'd7, 1, 2'd3, 0);
    issue(1, 5'd7, 1, 5'd0, 0, 5'd0, 0, 2'd1, 0);
    check_eq("l3_stall1", 32'(stall), 32'd1);
    hold();
    check_eq("l3_stall2", 32'(stall), 32'd1);
    hold();
    check_eq("l3_stall3", 32'(stall), 32'd0);
    nop();
    check_eq("l3_fwdA", 32'(ex_fwdA), 32'd3);
    check_eq("l3_cnt", 32'(stall_cnt), 32'd4);

    // Suppression: r0 writer, regWr=0, unused operands
    issue(1, 5'd0, 0, 5'd0, 0, 5'd0, 1, 2'd2, 0);
    issue(1, 5'd0, 1, 5'd0, 1, 5'd0, 0, 2'd1, 0);
    check_eq("r0_stall", 32'(stall), 32'd0);
    nop();
    check_eq("r0_fwdA", 32'(ex_fwdA), 32'd0);
    check_eq("r0_fwdB", 32'(ex_fwdB), 32'd0);
    issue(1, 5'd0, 0, 5'd0, 0, 5'd8, 0, 2'd2, 0);
    issue(1, 5'd8, 1, 5'd0, 0, 5'd0, 0, 2'd1, 0);
    check_eq("nowr_stall", 32'(stall), 32'd0);
    nop();
    check_eq("nowr_fwdA", 32'(ex_fwdA), 32'd0);
    issue(1, 5'd0, 0, 5'd0, 0, 5'd9, 1, 2'd2, 0);
    issue(1, 5'd9, 0, 5'd9, 0, 5'd0, 0, 2'd1, 0);
    check_eq("unused_stall", 32'(stall), 32'd0);
    nop();
    check_eq("unused_fwdB", 32'(ex_fwdB), 32'd0);

    // Latency code 0 behaves as ALU
    issue(1, 5'd0, 0, 5'd0, 0, 5'd10, 1, 2'd0, 0);
    issue(1, 5'd10, 1, 5'd0, 0, 5'd0, 0, 2'd1, 0);
    check_eq("lat0_stall", 32'(stall), 32'd0);
    nop();
    check_eq("lat0_fwdA", 32'(ex_fwdA), 32'd1);

    // Flush releases a stall and the flushed writer is not tracked
    issue(1, 5'd0, 0, 5'd0, 0, 5'd11, 1, 2'd3, 0);
    issue(1, 5'd11, 1, 5'd0, 0, 5'd11, 1, 2'd1, 0);
    check_eq("fl_stall_pre", 32'(stall), 32'd1);
    issue(1, 5'd11, 1, 5'd0, 0, 5'd11, 1, 2'd1, 1);
    check_eq("fl_stall", 32'(stall), 32'd0);
    issue(1, 5'd11, 1, 5'd0, 0, 5'd0, 0, 2'd1, 0);
    check_eq("fl_bubble_fwdA", 32'(ex_fwdA), 32'd0);
    check_eq("fl_next_stall", 32'(stall), 32'd0);
    nop();
    check_eq("fl_fwdA", 32'(ex_fwdA), 32'd3);
    check_eq("fl_cnt", 32'(stall_cnt), 32'd5);

    // Reset in the middle of a stall discards tracking
    issue(1, 5'd0, 0, 5'd0, 0, 5'd12, 1, 2'd3, 0);
    issue(1, 5'd12, 1, 5'd0, 0, 5'd0, 0, 2'd1, 0);
    check_eq("mr_stall_pre", 32'(stall), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_eq("mr_stall", 32'(stall), 32'd0);
    check_eq("mr_cnt", 32'(stall_cnt), 32'd0);
    check_eq("mr_fwdA", 32'(ex_fwdA), 32'd0);

    // Saturation: dependent latency-3 chain stalls 2 of every 3 cycles
    repeat (3) nop();
    issue(1, 5'd1, 1, 5'd0, 0, 5'd1, 1, 2'd3, 0);
    repeat (420) @(posedge clk);
    #1;
    check_eq("sat_cnt", 32'(stall_cnt), 32'd255);
    repeat (6) @(posedge clk);
    #1;
    check_eq("sat_hold", 32'(stall_cnt), 32'd255);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Parametrised forwarding and interlock unit at the ID/EX boundary of the pipeline. It tracks in-flight register writers in an internal shadow of the EX..EX+DEPTH-1 stages, with per-writer result latency. For the instruction leaving ID it produces registered forwarding selects that are valid during its EX cycle. When a needed result is not yet forwardable, it raises a load-use style stall and inserts bubbles; it also keeps a saturating stall counter.

## Interface
- RA_W, 5, register address width
- DEPTH, 3, tracked stages after ID (entry k = instruction in stage EX+k); ≥2
- LAT_W, 2, width of latency code
- SEL_W, $clog2(DEPTH+1), width of forwarding selects
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- id_valid  in  1  ID holds a real instruction
- id_rs, id_rt  in  RA_W  source registers of ID instruction
- id_rs_used, id_rt_used  in  1  operand actually read
- id_rw  in  RA_W  destination register
- id_regWr  in  1  instruction writes id_rw
- id_lat  in  LAT_W  result latency: 1 = ALU (forwardable from EX+1), 2 = load, up to DEPTH; 0 treated as 1
- id_flush  in  1  kill the ID instruction this cycle
- stall  out  1  hold PC/IF/ID, bubble into EX (combinational)
- ex_fwdA, ex_fwdB  out  SEL_W  EX-stage operand source: 0 = register file, d = producer d stages ahead (1 = EX/MEM, 2 = MEM/WB, ...)
- stall_cnt  out  CNT_W  saturating count of stall cycles

## Operation
- Scoreboard: DEPTH entries {v, rw, lat}. Every cycle it shifts k→k+1. Entry DEPTH-1 is discarded; the register file is write-through, so that value is read normally.
- Entry 0 load:
  - id_flush=1 or stall=1 or id_valid=0: bubble (v=0).
  - Otherwise: v = id_regWr & (id_rw≠0); rw = id_rw; lat = max(id_lat,1).
- Match for operand X ∈ {rs, rt}: entry k matches if X_used, id_valid, v, rw==X, X≠0. Only the youngest match (smallest k) is considered.
  - Distance d = k+1.
  - Forwardable if d ≥ lat; then sel = d.
  - Not forwardable: hazard.
  - No match: sel = 0.
- stall = id_valid & ~id_flush & (hazardA | hazardB). An unready youngest match stalls even when an older match exists.
- ex_fwdA/B register update:
  - Transfer cycle (id_valid & ~stall & ~id_flush): take the computed sels.
  - All other cycles: 0.
- The relative distance between producer and consumer is preserved across the ID→EX transfer. A stalled consumer therefore re-evaluates each cycle with distances grown by one.
- stall_cnt increments on each cycle with stall=1 and saturates at all-ones.
- Flush has priority over stall. A flush during a stall releases it the same cycle and inserts a bubble.

## Timing
- Reset (rst=1 at clk edge): all entries v=0, ex_fwdA=ex_fwdB=0, stall_cnt=0. stall is therefore 0 in the first cycle after reset.
- Reset mid-operation discards all in-flight tracking; no stall persists after it.
- stall is combinational from current entries and ID inputs, with no register delay. The upstream holds ID in that same cycle.
- ex_fwdA/B have latency 1: computed in the ID cycle, valid throughout the following EX cycle.
- Stall length for a youngest match at entry k with latency lat: lat-(k+1) cycles.
  - ALU→consumer: 0.
  - Load→consumer back-to-back: 1.
  - lat=DEPTH at k=0: DEPTH-1.
- Simultaneous rs and rt hazards: one stall signal covers both; it is released when both are forwardable.
- Writes to r0 are never tracked and never forwarded.
- A match at k = DEPTH-1 with d ≥ lat forwards with sel = DEPTH. Beyond that, the value comes from the register file.

## Test plan
- Reset: assert rst 2 cycles with random inputs → stall=0, ex_fwdA=ex_fwdB=0, stall_cnt=0.
- ALU chain: add r3 (lat=1), then next cycle an ID instruction with rs=r3 → stall=0; ex_fwdA=1 in its EX cycle.
- Load-use: lw r4 (lat=2), then rs=r4, rt=r4 → stall=1 for exactly 1 cycle, stall_cnt=1; then ex_fwdA=ex_fwdB=2, and ex_fwdA/B=0 during the bubble.
- Youngest-wins / DEPTH edge: write r5 at distance 2 and 1, consumer rt=r5 → ex_fwdB=1. Then a consumer with rs=r5 whose only writer is 4 stages ahead (DEPTH=3) → ex_fwdA=0.
- Suppression: writer to r0, writer with regWr=0, and a match with rt_used=0 → all selects 0, no stall.
- Flush/saturation: id_flush=1 during a load-use stall → stall=0 that cycle, bubble inserted. Force 2^CNT_W+3 stall cycles → stall_cnt holds all-ones.
